// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: the NOP returned for unmapped fetches
// and the fetch-memory FSM state encoding.
package rv32i_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mem_state_t;

endpackage

// File: rtl/instr_memory_if.sv
// Fetch-side request/ack bus between the fetch stage and instr_memory.
// Signals: byte address, req, returned word, ack (+ err with INSTR_MEM_ERR_EN).
interface instr_memory_if;

  logic [31:0] main_memory_instr_addr;
  logic        main_memory_instr_req;
  logic [31:0] main_memory_instr;
  logic        main_memory_instr_ack;
`ifdef INSTR_MEM_ERR_EN
  logic        main_memory_instr_err;
`endif

`ifdef INSTR_MEM_ERR_EN
  modport master (
    output main_memory_instr_addr,
    output main_memory_instr_req,
    input  main_memory_instr,
    input  main_memory_instr_ack,
    input  main_memory_instr_err
  );

  modport slave (
    input  main_memory_instr_addr,
    input  main_memory_instr_req,
    output main_memory_instr,
    output main_memory_instr_ack,
    output main_memory_instr_err
  );
`else
  modport master (
    output main_memory_instr_addr,
    output main_memory_instr_req,
    input  main_memory_instr,
    input  main_memory_instr_ack
  );

  modport slave (
    input  main_memory_instr_addr,
    input  main_memory_instr_req,
    output main_memory_instr,
    output main_memory_instr_ack
  );
`endif

endinterface

// File: rtl/instr_mem_array.sv
// Word storage: one synchronous write port, one combinational read port.
// Ports: clk, i_we/i_waddr/i_wdata (write), i_raddr/o_rdata (read).
module instr_mem_array #(
  parameter int    DEPTH_WORDS = 1024,
  parameter string INIT_FILE   = "",
  localparam int   AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  initial begin
    for (int i = 0; i < DEPTH_WORDS; i++)
      r_mem[i] = '0;
  end

  always_ff @(posedge clk) begin
    if (i_we)
      r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instr_memory.sv
// Instruction memory with request/ack FSM, wait states and load port.
// Ports: clk, rst (sync, active-low), bus (instr_memory_if.slave),
// load_we/load_addr/load_data. Macro INSTR_MEM_ERR_EN adds the err output.
module instr_memory
  import rv32i_pkg::*;
#(
  parameter int    DEPTH_WORDS = 1024,
  parameter int    WAIT_STATES = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic                 clk,
  input  logic                 rst,
  instr_memory_if.slave        bus,
  input  logic                 load_we,
  input  logic [31:0]          load_addr,
  input  logic [31:0]          load_data
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [30:0] DEPTH_L = 31'(DEPTH_WORDS);
  localparam logic [3:0] WS_M1 =
    4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

  function automatic logic in_range(input logic [29:0] idx);
    return {1'b0, idx} < DEPTH_L;
  endfunction

  mem_state_t  r_state;
  mem_state_t  w_next;
  logic [29:0] r_idx;
  logic        r_mis;
  logic [3:0]  r_cnt;
  logic [31:0] r_instr;

  logic        w_req;
  logic        w_cap;
  logic [29:0] w_ridx;
  logic        w_rmis;
  logic        w_rin;
  logic [29:0] w_widx;
  logic        w_we;
  logic        w_byp;
  logic [31:0] w_arr;
  logic [31:0] w_rdata;
  logic        w_unused_bits;

  assign w_req = bus.main_memory_instr_req;
  assign w_cap = w_req && (r_state != WAIT);

  // Outside WAIT the word is read straight from the live address
  // (zero-wait capture); inside WAIT the latched index is used.
  assign w_ridx = (r_state == WAIT) ? r_idx
                : bus.main_memory_instr_addr[31:2];
  assign w_rmis = (r_state == WAIT) ? r_mis
                : |bus.main_memory_instr_addr[1:0];
  assign w_rin  = in_range(w_ridx);

  assign w_widx = load_addr[31:2];
  assign w_we   = load_we && in_range(w_widx);
  assign w_byp  = w_we && (w_widx == w_ridx);

  assign w_unused_bits = ^{load_addr[1:0], w_rmis};

  instr_mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .INIT_FILE   (INIT_FILE)
  ) u_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_widx[AW-1:0]),
    .i_wdata (load_data),
    .i_raddr (w_ridx[AW-1:0]),
    .o_rdata (w_arr)
  );

  always_comb begin
    w_rdata = w_arr;
    if (!w_rin)
      w_rdata = NOP;
    else if (w_byp)
      w_rdata = load_data;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_req)
          w_next = (WAIT_STATES == 0) ? RESP : WAIT;
      end
      WAIT: begin
        if (!w_req)
          w_next = IDLE;
        else if (r_cnt == 4'd0)
          w_next = RESP;
      end
      RESP: begin
        if (w_req)
          w_next = (WAIT_STATES == 0) ? RESP : WAIT;
        else
          w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_mis   <= 1'b0;
      r_cnt   <= '0;
      r_instr <= '0;
    end else begin
      r_state <= w_next;
      if (w_cap) begin
        r_idx <= bus.main_memory_instr_addr[31:2];
        r_mis <= |bus.main_memory_instr_addr[1:0];
        r_cnt <= WS_M1;
      end else if (r_state == WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      // Data is registered on the edge that enters (or re-enters) RESP.
      if (w_next == RESP)
        r_instr <= w_rdata;
    end
  end

  assign bus.main_memory_instr     = r_instr;
  assign bus.main_memory_instr_ack = (r_state == RESP);

`ifdef INSTR_MEM_ERR_EN
  logic r_err;

  always_ff @(posedge clk) begin
    if (!rst)
      r_err <= 1'b0;
    else if (w_next == RESP)
      r_err <= w_rmis || !w_rin;
  end

  assign bus.main_memory_instr_err = r_err;
`endif

endmodule

// File: tb/tb_instr_memory.sv
// Scoreboard bench for instr_memory: one zero-wait and one 3-wait instance
// sharing clock, reset and load bus.
module tb_instr_memory;
  import rv32i_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_we = 1'b0;
  logic [31:0] load_addr = '0;
  logic [31:0] load_data = '0;

  always #5 clk = ~clk;

  instr_memory_if b0 ();
  instr_memory_if b3 ();

  instr_memory #(
    .DEPTH_WORDS (1024),
    .WAIT_STATES (0),
    .INIT_FILE   ("")
  ) u0 (
    .clk       (clk),
    .rst       (rst),
    .bus       (b0),
    .load_we   (load_we),
    .load_addr (load_addr),
    .load_data (load_data)
  );

  instr_memory #(
    .DEPTH_WORDS (1024),
    .WAIT_STATES (3),
    .INIT_FILE   ("")
  ) u3 (
    .clk       (clk),
    .rst       (rst),
    .bus       (b3),
    .load_we   (load_we),
    .load_addr (load_addr),
    .load_data (load_data)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t q0[$];
  exp_t q3[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic [31:0] prog [8] = '{
    32'h0050_0093, 32'h00A0_0113, 32'h0020_81B3, 32'h4011_0233,
    32'h0000_006F, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333
  };

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic mon(input string nm, input logic [31:0] d,
                     input logic e, ref exp_t q[$]);
    exp_t x;
    if (q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_unexpected_ack: got ack=1 data %h expected ack=0",
               nm, d);
    end else begin
      x = q.pop_front();
      chk({nm, "_data"}, d, x.data);
`ifdef INSTR_MEM_ERR_EN
      chk({nm, "_err"}, 32'(e), 32'(x.err));
`else
      if (e && x.err) begin end
`endif
    end
  endtask

  logic w_e0, w_e3;
`ifdef INSTR_MEM_ERR_EN
  assign w_e0 = b0.main_memory_instr_err;
  assign w_e3 = b3.main_memory_instr_err;
`else
  assign w_e0 = 1'b0;
  assign w_e3 = 1'b0;
`endif

  always @(negedge clk) begin
    if (b0.main_memory_instr_ack)
      mon("u0", b0.main_memory_instr, w_e0, q0);
    if (b3.main_memory_instr_ack)
      mon("u3", b3.main_memory_instr, w_e3, q3);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    load_we   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_we   = 1'b0;
  endtask

  task automatic rd0(input logic [31:0] a, input logic [31:0] d,
                     input logic e);
    b0.main_memory_instr_req  = 1'b1;
    b0.main_memory_instr_addr = a;
    q0.push_back('{d, e});
    tick();
    chk("u0_ack", 32'(b0.main_memory_instr_ack), 32'd1);
    b0.main_memory_instr_req = 1'b0;
    tick();
  endtask

  task automatic rd3(input logic [31:0] a, input logic [31:0] d,
                     input logic e);
    int k;
    b3.main_memory_instr_req  = 1'b1;
    b3.main_memory_instr_addr = a;
    q3.push_back('{d, e});
    k = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (k == 0 && i >= 2)
        b3.main_memory_instr_addr = 32'h0000_0018;
      if (b3.main_memory_instr_ack) begin
        k = i;
        break;
      end
    end
    chk("u3_latency", 32'(k), 32'd4);
    b3.main_memory_instr_req = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    b0.main_memory_instr_req  = 1'b0;
    b0.main_memory_instr_addr = '0;
    b3.main_memory_instr_req  = 1'b0;
    b3.main_memory_instr_addr = '0;
    rst = 1'b0;
    repeat (3) tick();
    chk("rst_u0_ack", 32'(b0.main_memory_instr_ack), 32'd0);
    chk("rst_u0_instr", b0.main_memory_instr, 32'd0);
    chk("rst_u3_ack", 32'(b3.main_memory_instr_ack), 32'd0);
    chk("rst_u3_instr", b3.main_memory_instr, 32'd0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 8; i++)
      load(32'(i * 4), prog[i]);
    // Out-of-range write must not alias onto word 0.
    load(32'h0000_4000, 32'hBAD0_BAD0);

    // Zero-wait streaming: one word per cycle.
    b0.main_memory_instr_req  = 1'b1;
    b0.main_memory_instr_addr = 32'h0;
    q0.push_back('{prog[0], 1'b0});
    tick();
    chk("stream_ack1", 32'(b0.main_memory_instr_ack), 32'd1);
    b0.main_memory_instr_addr = 32'h4;
    q0.push_back('{prog[1], 1'b0});
    tick();
    chk("stream_ack2", 32'(b0.main_memory_instr_ack), 32'd1);
    b0.main_memory_instr_addr = 32'h8;
    q0.push_back('{prog[2], 1'b0});
    tick();
    chk("stream_ack3", 32'(b0.main_memory_instr_ack), 32'd1);
    b0.main_memory_instr_req = 1'b0;
    tick();
    chk("stream_ack_low", 32'(b0.main_memory_instr_ack), 32'd0);
    chk("hold_instr", b0.main_memory_instr, prog[2]);

    // Three wait states; address change in WAIT is ignored.
    rd3(32'h10, prog[4], 1'b0);

    // Abort during WAIT, then a normal request.
    b3.main_memory_instr_req  = 1'b1;
    b3.main_memory_instr_addr = 32'h8;
    tick();
    b3.main_memory_instr_req = 1'b0;
    repeat (6) tick();
    rd3(32'h0C, prog[3], 1'b0);

    // Write-first on the capture edge.
    b0.main_memory_instr_req  = 1'b1;
    b0.main_memory_instr_addr = 32'h10;
    load_we   = 1'b1;
    load_addr = 32'h10;
    load_data = 32'hDEAD_BEEF;
    q0.push_back('{32'hDEAD_BEEF, 1'b0});
    tick();
    load_we = 1'b0;
    chk("byp_ack", 32'(b0.main_memory_instr_ack), 32'd1);
    b0.main_memory_instr_req = 1'b0;
    tick();
    rd3(32'h10, 32'hDEAD_BEEF, 1'b0);

    // Range and alignment.
    rd0(32'h0000_4000, NOP, 1'b1);
    rd0(32'h0000_0006, prog[1], 1'b1);
    rd0(32'h0000_0000, prog[0], 1'b0);
    rd0(32'h0000_0FFC, 32'h0, 1'b0);

    // Reset in the middle of WAIT.
    b3.main_memory_instr_req  = 1'b1;
    b3.main_memory_instr_addr = 32'h14;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rstw_u3_ack", 32'(b3.main_memory_instr_ack), 32'd0);
    chk("rstw_u3_instr", b3.main_memory_instr, 32'd0);
    chk("rstw_u0_instr", b0.main_memory_instr, 32'd0);
    rst = 1'b1;
    b3.main_memory_instr_req = 1'b0;
    repeat (6) tick();
    chk("rstw_u3_idle", 32'(b3.main_memory_instr_ack), 32'd0);
    rd3(32'h14, prog[5], 1'b0);
    rd0(32'h1C, prog[7], 1'b0);

    repeat (3) tick();
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q3_drained", 32'(q3.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
